reg_transfer_ctrl: RTL and testbench
====================================

Name: reg_transfer_ctrl

Overview:
- Sequences register-to-register transfers (TAX, TXA, TAY, TYA, TSX, TXS) between the CPU's 8-bit register instances over the shared internal bus.
- Accepts one transfer request through a valid/ready handshake. Drives the source register's bus enable, then pulses the destination register's load strobe.
- Produces N/Z flag-update strobes for the status logic.
- Sits between instruction decode and the A/X/Y/SP register instances.

Parameters:
- NUM_REGS, 4, number of bus-attached registers (index 0=A, 1=X, 2=Y, 3=SP)
- IDX_W, 2, width of register index fields (clog2 of NUM_REGS)
- NOFLAG_IDX, 3, destination index whose load does not update flags (SP, for TXS)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  transfer request present
- req_ready  out  1  controller can accept a request
- req_src  in  IDX_W  source register index
- req_dst  in  IDX_W  destination register index
- abort  in  1  synchronous cancel of an in-flight transfer
- bus_data  in  8  internal bus value (driven by the selected source register)
- bus_oe  out  NUM_REGS  one-hot output enable: source register drives the bus
- load  out  NUM_REGS  one-hot load strobe to the destination register
- flag_load  out  1  status N/Z update strobe
- flag_n  out  1  N value (bus_data[7]), valid when flag_load=1
- flag_z  out  1  Z value (bus_data==0), valid when flag_load=1
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- err  out  1  qualifies done: transfer rejected or aborted, no load issued

Behaviour:
- FSM states: IDLE, DRIVE, LOAD, DONE. src/dst are captured into registers at acceptance. All outputs are decoded from state plus captured indices; no input-to-output path except flag_n/flag_z from bus_data.
- Reset (reset=0, asynchronous): state=IDLE, captured indices=0, err flag cleared. While reset=0: bus_oe=0, load=0, flag_load=0, busy=0, done=0, err=0, req_ready=0. Reset mid-transfer aborts with no load and no done.
- IDLE: req_ready=1 (reset high). Acceptance happens on the edge where req_valid && req_ready.
  - If src!=dst, go to DRIVE.
  - If src==dst or either index >= NUM_REGS, go to DONE with err latched to 1.
- DRIVE: bus_oe[src]=1, busy=1, req_ready=0. Next state is LOAD.
  - abort=1 in DRIVE: go to DONE with err=1, no load.
- LOAD: bus_oe[src]=1, load[dst]=1, busy=1.
  - flag_load=1 unless dst==NOFLAG_IDX; flag_n=bus_data[7], flag_z=(bus_data==8'h00).
  - Next state is DONE with err=0. abort is ignored in LOAD; the load commits.
- DONE: done=1, err=latched err, busy=1, req_ready=0. Next state is IDLE.
- abort in IDLE or DONE: ignored.
- Timing: request accepted at edge k. DRIVE during cycle k..k+1, LOAD cycle k+1..k+2, done high cycle k+2..k+3. The destination register holds the new value after edge k+2.
- Throughput: one transfer per 4 cycles. A back-to-back request held valid is accepted on the edge that leaves the IDLE cycle following DONE.
- Invariants:
  - bus_oe and load are each at most one-hot.
  - load never asserts without bus_oe of a different index in the same cycle.
  - flag_load=1 only in LOAD.
- req_src/req_dst are don't-care outside acceptance; changes mid-transfer have no effect.

Test Plan:
- Reset: hold reset=0 for 3 cycles with req_valid=1 -> all outputs 0, no acceptance. Release -> req_ready=1 next cycle.
- TAX (src=0, dst=1, A holds 8'h80): bus_oe=0001 for 2 cycles, load=0010 in second. flag_load=1, flag_n=1, flag_z=0. done=1, err=0. X=8'h80 afterwards.
- TXS (src=1, dst=3, bus_data=8'h00): load=1000, flag_load=0 throughout. done=1, err=0.
- Invalid request (src=dst=2) -> no bus_oe/load ever asserted. done=1, err=1 on the cycle after acceptance, then IDLE.
- abort=1 during DRIVE of TYA -> load stays 0000, done=1, err=1. abort=1 during LOAD -> load commits, err=0.
- Back-to-back: req_valid held high with TAY then TYA -> accepts exactly 4 cycles apart, never while busy. Asserting reset=0 in LOAD of the second transfer -> outputs 0 immediately, no done.

Source files
------------

// File: rtl/reg_transfer_ctrl.sv
// reg_transfer_ctrl: sequences register-to-register transfers over the internal bus.
// A transfer goes through the states IDLE -> DRIVE -> LOAD -> DONE; a rejected transfer goes straight from IDLE to DONE.
module reg_transfer_ctrl #(
  parameter int NUM_REGS   = 4,
  parameter int IDX_W      = 2,
  parameter int NOFLAG_IDX = 3
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [IDX_W-1:0]    req_src_i,
  input  logic [IDX_W-1:0]    req_dst_i,
  input  logic                abort_i,
  input  logic [7:0]          bus_data_i,
  output logic [NUM_REGS-1:0] bus_oe_o,
  output logic [NUM_REGS-1:0] load_o,
  output logic                flag_load_o,
  output logic                flag_n_o,
  output logic                flag_z_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
);
  typedef enum logic [1:0] {IDLE, DRIVE, LOAD, DONE} state_t;
  state_t           state_q;
  logic [IDX_W-1:0] src_q, dst_q;
  logic             err_q, rdy_q;
  logic             accept, bad;
  assign accept = req_valid_i && rdy_q;
  assign bad    = (req_src_i == req_dst_i) || (int'(req_src_i) >= NUM_REGS) || (int'(req_dst_i) >= NUM_REGS);
  // rdy_q stays low for the first cycle after reset, so no request is accepted until it rises.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          rdy_q <= !accept;
          if (accept) begin
            src_q   <= req_src_i;
            dst_q   <= req_dst_i;
            err_q   <= bad;
            state_q <= bad ? DONE : DRIVE;
          end
        end
        DRIVE: begin
          err_q   <= abort_i;
          state_q <= abort_i ? DONE : LOAD;
        end
        LOAD: begin
          err_q   <= 1'b0;
          state_q <= DONE;
        end
        default: begin
          rdy_q   <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end
  assign req_ready_o = rdy_q;
  assign bus_oe_o    = (state_q == DRIVE || state_q == LOAD) ? NUM_REGS'(1) << src_q : '0;
  assign load_o      = (state_q == LOAD) ? NUM_REGS'(1) << dst_q : '0;
  assign flag_load_o = (state_q == LOAD) && (dst_q != IDX_W'(NOFLAG_IDX));
  assign flag_n_o    = flag_load_o & bus_data_i[7];
  assign flag_z_o    = flag_load_o & ~|bus_data_i;
  assign busy_o      = state_q != IDLE;
  assign done_o      = state_q == DONE;
  assign err_o       = done_o & err_q;
endmodule

// File: tb/tb_reg_transfer_ctrl.sv
// tb_reg_transfer_ctrl: table-driven cycle vectors plus latency and register-content sequences.
module tb_reg_transfer_ctrl;
  logic       clk = 1'b0, rst_n = 1'b0, vld = 1'b0, abt = 1'b0;
  logic [1:0] src = '0, dst = '0;
  logic       rdy, fl, fn, fz, bsy, dn, er;
  logic [3:0] oe, ld;
  logic [7:0] bus;
  logic [7:0] regs [4] = '{8'h80, 8'h00, 8'h5A, 8'hFF};
  int tests = 0, fails = 0;

  reg_transfer_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(vld), .req_ready_o(rdy),
    .req_src_i(src), .req_dst_i(dst), .abort_i(abt), .bus_data_i(bus),
    .bus_oe_o(oe), .load_o(ld), .flag_load_o(fl), .flag_n_o(fn), .flag_z_o(fz),
    .busy_o(bsy), .done_o(dn), .err_o(er)
  );

  always #5 clk = ~clk;

  // Register file and shared bus model: the enabled source drives, the strobed destination loads.
  always_comb begin
    bus = 8'h00;
    for (int i = 0; i < 4; i++) if (oe[i]) bus = regs[i];
  end
  always @(posedge clk) for (int i = 0; i < 4; i++) if (ld[i]) regs[i] <= bus;

  always @(negedge clk) begin
    tests++;
    if (!$onehot0(oe) || !$onehot0(ld) || (ld != 0 && (oe == 0 || (oe & ld) != 0)) || (fl && ld == 0)) begin
      fails++;
      $display("FAIL invariant t=%0t oe=%b ld=%b fl=%b", $time, oe, ld, fl);
    end
  end

  typedef struct {
    logic       rst, vld;
    logic [1:0] s, d;
    logic       ab;
    logic [14:0] exp;  // {rdy, oe, ld, fl, fn, fz, bsy, dn, er}
  } vec_t;
  vec_t q[$];

  task automatic add(input logic r, v, input logic [1:0] s, d, input logic a,
                     input logic ry, input logic [3:0] o, l, input logic f, n, z, b, dd, e);
    q.push_back('{r, v, s, d, a, {ry, o, l, f, n, z, b, dd, e}});
  endtask

  task automatic chk(input string name, input logic [7:0] act, exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  initial begin
    int lat;
    logic seen_n;
    //  rst vld s  d  ab   rdy oe       ld       fl fn fz bsy dn er
    add(0, 1, 0, 1, 0,   0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0,   0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0,   0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 0,   0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 0,   1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 3, 0,   1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);  // TXS accepted
    add(1, 0, 2, 0, 0,   0, 4'b0010, 4'b0000, 0, 0, 0, 1, 0, 0);
    add(1, 0, 2, 0, 0,   0, 4'b0010, 4'b1000, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0,   0, 4'b0000, 4'b0000, 0, 0, 0, 1, 1, 0);
    add(1, 1, 0, 1, 0,   1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);  // TAX accepted
    add(1, 0, 0, 0, 0,   0, 4'b0001, 4'b0000, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0,   0, 4'b0001, 4'b0010, 1, 1, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0,   0, 4'b0000, 4'b0000, 0, 0, 0, 1, 1, 0);
    add(1, 1, 2, 2, 0,   1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);  // src==dst rejected
    add(1, 0, 0, 0, 0,   0, 4'b0000, 4'b0000, 0, 0, 0, 1, 1, 1);
    add(1, 1, 2, 0, 0,   1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);  // TYA, aborted in DRIVE
    add(1, 0, 0, 0, 1,   0, 4'b0100, 4'b0000, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 1,   0, 4'b0000, 4'b0000, 0, 0, 0, 1, 1, 1);
    add(1, 1, 2, 0, 1,   1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);  // TYA, abort in LOAD ignored
    add(1, 0, 0, 0, 0,   0, 4'b0100, 4'b0000, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 1,   0, 4'b0100, 4'b0001, 1, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0,   0, 4'b0000, 4'b0000, 0, 0, 0, 1, 1, 0);
    add(1, 1, 0, 2, 0,   1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);  // TAY accepted, TYA then held
    add(1, 1, 2, 0, 0,   0, 4'b0001, 4'b0000, 0, 0, 0, 1, 0, 0);
    add(1, 1, 2, 0, 0,   0, 4'b0001, 4'b0100, 1, 0, 0, 1, 0, 0);
    add(1, 1, 2, 0, 0,   0, 4'b0000, 4'b0000, 0, 0, 0, 1, 1, 0);
    add(1, 1, 2, 0, 0,   1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);  // TYA accepted 4 cycles later
    add(1, 0, 0, 0, 0,   0, 4'b0100, 4'b0000, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0,   0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);  // reset during LOAD
    add(0, 0, 0, 0, 0,   0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0,   0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0,   1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);
    foreach (q[i]) begin
      rst_n = q[i].rst; vld = q[i].vld; src = q[i].s; dst = q[i].d; abt = q[i].ab;
      @(negedge clk);
      tests++;
      if ({rdy, oe, ld, fl, fn, fz, bsy, dn, er} !== q[i].exp) begin
        fails++;
        $display("FAIL vec%0d got %b want %b", i, {rdy, oe, ld, fl, fn, fz, bsy, dn, er}, q[i].exp);
      end
      @(posedge clk); #1;
    end
    chk("reg_A", regs[0], 8'h5A);
    chk("reg_X", regs[1], 8'h80);
    chk("reg_Y", regs[2], 8'h5A);
    chk("reg_SP", regs[3], 8'h00);
    // TXA: done must follow acceptance by exactly three cycles, carrying X into A.
    vld = 1'b1; src = 2'd1; dst = 2'd0; abt = 1'b0;
    @(negedge clk);
    chk("txa_ready", {7'd0, rdy}, 8'd1);
    @(posedge clk); #1;
    vld = 1'b0;
    lat = 0; seen_n = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (fl) seen_n = fn;
    end while (!dn && lat < 8);
    chk("txa_latency", 8'(lat), 8'd3);
    chk("txa_err", {7'd0, er}, 8'd0);
    chk("txa_flag_n", {7'd0, seen_n}, 8'd1);
    @(posedge clk); #1;
    chk("txa_reg_A", regs[0], 8'h80);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
